ps2_event_sequencer: RTL



---
 rtl/ps2_event_sequencer_if.sv | 11 +
 rtl/ps2_event_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_event_sequencer_if.sv
// Key-event stream from the PS/2 event sequencer to its consumers.
interface ps2_event_sequencer_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;

  modport master (output ev_valid, ev_code, ev_ext, ev_break, input ev_ready);
  modport slave  (input ev_valid, ev_code, ev_ext, ev_break, output ev_ready);
endinterface

// File: rtl/ps2_event_sequencer.sv
// PS/2 scan-code sequencer: flag synchronizer, E0/F0 prefix FSM, prefix timeout,
// typematic repeat filter and a first-word-fall-through event FIFO.
module ps2_event_sequencer #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned FILTER_REPEAT  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 ps2_code,
  input  logic                       ps2_flag,
  ps2_event_sequencer_if.master      ev,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } event_t;

  // Flag synchronizer; the rising edge after f2 marks a new byte
  logic f1, f2, f3;
  logic strobe;

  always_ff @(posedge clk) begin
    if (reset) begin
      f1 <= 1'b0;
      f2 <= 1'b0;
      f3 <= 1'b0;
    end else begin
      f1 <= ps2_flag;
      f2 <= f1;
      f3 <= f2;
    end
  end

  assign strobe = f2 & ~f3;

  logic is_prefix;
  logic is_status;

  assign is_prefix = (ps2_code == 8'hE0) || (ps2_code == 8'hF0);

  always_comb begin
    case (ps2_code)
      8'h00, 8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_status = 1'b1;
      default:                                  is_status = 1'b0;
    endcase
  end

  // Prefix FSM
  state_t        state, state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          timeout;
  logic          emit, emit_ext, emit_brk;

  assign timeout = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (strobe) begin
      case (state)
        IDLE: begin
          if (ps2_code == 8'hE0)      state_nxt = EXT;
          else if (ps2_code == 8'hF0) state_nxt = BRK;
        end
        EXT: begin
          if (ps2_code == 8'hF0)      state_nxt = EXT_BRK;
          else if (ps2_code != 8'hE0) state_nxt = IDLE;
        end
        BRK: begin
          if (ps2_code == 8'hE0)      state_nxt = EXT_BRK;
          else if (ps2_code != 8'hF0) state_nxt = IDLE;
        end
        EXT_BRK: begin
          if (!is_prefix)             state_nxt = IDLE;
        end
        default:                      state_nxt = IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = IDLE;
    end
  end

  // Status bytes are only filtered between events, never after a prefix
  always_comb begin
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (strobe) begin
      case (state)
        IDLE:    emit = !is_prefix && !is_status;
        EXT:     begin emit = !is_prefix; emit_ext = 1'b1; end
        BRK:     begin emit = !is_prefix; emit_brk = 1'b1; end
        EXT_BRK: begin emit = !is_prefix; emit_ext = 1'b1; emit_brk = 1'b1; end
        default: emit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                          tmo_cnt <= '0;
    else if (strobe)                    tmo_cnt <= '0;
    else if (state == IDLE || timeout)  tmo_cnt <= '0;
    else                                tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Repeat filter: drop makes of the key currently held down
  logic suppress;

  generate
    if (FILTER_REPEAT != 0) begin : g_filter
      logic       held_valid;
      logic       held_ext;
      logic [7:0] held_code;
      logic       held_match;

      assign held_match = held_valid && (held_ext == emit_ext) && (held_code == ps2_code);
      assign suppress   = emit && !emit_brk && held_match;

      always_ff @(posedge clk) begin
        if (reset) begin
          held_valid <= 1'b0;
          held_ext   <= 1'b0;
          held_code  <= 8'h00;
        end else if (emit) begin
          if (!emit_brk && !held_match) begin
            held_valid <= 1'b1;
            held_ext   <= emit_ext;
            held_code  <= ps2_code;
          end else if (emit_brk && held_match) begin
            held_valid <= 1'b0;
          end
        end
      end
    end else begin : g_no_filter
      assign suppress = 1'b0;
    end
  endgenerate

  // Event FIFO
  event_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push_req, full, do_push, do_pop;
  event_t        head;

  assign push_req = emit && !suppress;
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = ev.ev_valid && ev.ev_ready;
  assign do_push  = push_req && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= '{ext: emit_ext, brk: emit_brk, code: ps2_code};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && full && !do_pop) overflow <= 1'b1;
    end
  end

  assign head        = mem[rd_ptr];
  assign ev.ev_valid = (count != '0);
  assign ev.ev_code  = head.code;
  assign ev.ev_ext   = head.ext;
  assign ev.ev_break = head.brk;
  assign fifo_count  = count;

endmodule
